// File: rtl/sorted_unique_extract.sv
// Collapses a sorted input frame into (value, occurrence count) pairs, one per distinct value,
// and reports the frame's distinct-value total and any ordering violation.
module sorted_unique_extract #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_last,
  output logic             done,
  output logic [CW-1:0]    uniq_total,
  output logic             sort_err
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_val_q, cur_val_d;
  logic [CW-1:0]    cur_cnt_q, cur_cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    pair_cnt_q;
  logic             sort_err_d;

  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [CW-1:0]    load_cnt;
  logic             load_last;

  logic             reg_free;
  logic             accept;
  logic             emit;

  assign reg_free = !out_valid || out_ready;
  assign in_ready = (state_q != StFlush) && reg_free;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;
  assign done     = emit && out_last;
  // Occurrence count sticks at all-ones rather than wrapping.
  assign cnt_inc  = (cur_cnt_q == {CW{1'b1}}) ? cur_cnt_q : cur_cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    cur_val_d  = cur_val_q;
    cur_cnt_d  = cur_cnt_q;
    sort_err_d = sort_err;
    load       = 1'b0;
    load_data  = cur_val_q;
    load_cnt   = cur_cnt_q;
    load_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sort_err_d = 1'b0;
          if (in_last) begin
            load      = 1'b1;
            load_data = in_data;
            load_cnt  = CW'(1);
            load_last = 1'b1;
          end else begin
            cur_val_d = in_data;
            cur_cnt_d = CW'(1);
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          if (in_data == cur_val_q) begin
            cur_cnt_d = cnt_inc;
            if (in_last) begin
              load      = 1'b1;
              load_cnt  = cnt_inc;
              load_last = 1'b1;
              state_d   = StIdle;
            end
          end else begin
            // Out-of-order word still opens a new run; only the flag records it.
            if (in_data < cur_val_q) sort_err_d = 1'b1;
            load      = 1'b1;
            cur_val_d = in_data;
            cur_cnt_d = CW'(1);
            if (in_last) state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (reg_free) begin
          load      = 1'b1;
          load_last = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_val_q  <= '0;
      cur_cnt_q  <= '0;
      pair_cnt_q <= '0;
      sort_err   <= 1'b0;
      uniq_total <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      out_last   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_val_q <= cur_val_d;
      cur_cnt_q <= cur_cnt_d;
      sort_err  <= sort_err_d;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_count <= load_cnt;
        out_last  <= load_last;
      end else if (emit) begin
        out_valid <= 1'b0;
      end
      if (emit) begin
        if (out_last) begin
          uniq_total <= pair_cnt_q + CW'(1);
          pair_cnt_q <= '0;
        end else begin
          pair_cnt_q <= pair_cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sorted_unique_extract.sv
// Bench for sorted_unique_extract: directed frames plus random frames with random back-pressure,
// checked against a queue-based reference model. Two instances (CW=8, CW=4) share stimulus.
module tb_sorted_unique_extract;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, done, sort_err;
  logic [31:0] out_data;
  logic [7:0]  out_count, uniq_total;
  logic        in_ready4, out_valid4, out_last4, done4, sort_err4;
  logic [31:0] out_data4;
  logic [3:0]  out_count4, uniq_total4;

  sorted_unique_extract #(.WIDTH(32), .CW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_last(out_last), .done(done), .uniq_total(uniq_total),
    .sort_err(sort_err)
  );

  sorted_unique_extract #(.WIDTH(32), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_count(out_count4), .out_last(out_last4), .done(done4), .uniq_total(uniq_total4),
    .sort_err(sort_err4)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; int unsigned c; bit l;} pair_t;
  typedef struct {logic [31:0] d; logic [7:0] c8; logic [3:0] c4; bit l; int cyc;} rec_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          done_cnt = 0;
  int unsigned rdy_pct = 100;

  // Reference model: closed-but-unsent pairs, the open run, flag and totals.
  pair_t       q[$];
  rec_t        log_q[$];
  logic [31:0] run_val;
  int unsigned run_len = 0;
  bit          exp_err = 0;
  int unsigned emit_cnt = 0;
  int unsigned exp_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned c, input int unsigned mx);
    return (c > mx) ? mx : c;
  endfunction

  always @(negedge clk) out_ready <= 1'b1;
  always begin
    @(negedge clk);
    #1 out_ready = ($urandom_range(0, 99) < rdy_pct);
  end

  // Compare process: runs after inputs settle, then advances the model past the coming edge.
  always begin
    bit emit_m;
    bit exp_ready;
    bit exp_done;
    @(negedge clk);
    #2;
    cyc++;
    if (rst) begin
      q.delete();
      run_len   = 0;
      exp_err   = 0;
      emit_cnt  = 0;
      exp_total = 0;
    end else begin
      exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
      emit_m    = (q.size() != 0) && out_ready;
      exp_done  = emit_m ? q[0].l : 1'b0;
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_valid4", out_valid4, q.size() != 0);
      chk("in_ready", in_ready, exp_ready);
      chk("in_ready4", in_ready4, exp_ready);
      chk("done", done, exp_done);
      chk("done4", done4, exp_done);
      chk("sort_err", sort_err, exp_err);
      chk("sort_err4", sort_err4, exp_err);
      chk("uniq_total", uniq_total, exp_total % 256);
      chk("uniq_total4", uniq_total4, exp_total % 16);
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_data4", out_data4, q[0].d);
        chk("out_count", out_count, sat(q[0].c, 255));
        chk("out_count4", out_count4, sat(q[0].c, 15));
        chk("out_last", out_last, q[0].l);
        chk("out_last4", out_last4, q[0].l);
      end
      if (done) done_cnt++;
      if (emit_m) begin
        log_q.push_back('{out_data, out_count, out_count4, out_last, cyc});
        if (q[0].l) begin
          exp_total = emit_cnt + 1;
          emit_cnt  = 0;
        end else begin
          emit_cnt++;
        end
        void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
        acc_cyc = cyc;
        if (run_len == 0) begin
          exp_err = 0;
          run_val = in_data;
          run_len = 1;
        end else if (in_data == run_val) begin
          run_len++;
        end else begin
          if (in_data < run_val) exp_err = 1;
          q.push_back('{run_val, run_len, 1'b0});
          run_val = in_data;
          run_len = 1;
        end
        if (in_last) begin
          q.push_back('{run_val, run_len, 1'b1});
          run_len = 0;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #2;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 500 cycles");
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #2;
    while ((q.size() != 0 || run_len != 0) && n < 2000) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d pairs pending, required 0", q.size());
    end
    @(negedge clk);
    #3;
  endtask

  task automatic chk_rec(input string name, input int i, input logic [31:0] d, input int c8,
                         input int c4, input bit l);
    if (i >= log_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: pair %0d missing, got %0d pairs", name, i, log_q.size());
    end else begin
      chk({name, "_data"}, log_q[i].d, d);
      chk({name, "_cnt8"}, log_q[i].c8, c8);
      chk({name, "_cnt4"}, log_q[i].c4, c4);
      chk({name, "_last"}, log_q[i].l, l);
    end
  endtask

  initial begin
    logic [31:0] v;
    int          len;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_uniq_total", uniq_total, 0);
    chk("rst_in_ready", in_ready, 1);

    // Frame 1,1,2,5,5,5
    log_q.delete();
    done_cnt = 0;
    send_word(1, 0); send_word(1, 0); send_word(2, 0);
    send_word(5, 0); send_word(5, 0); send_word(5, 1);
    drain();
    chk("t1_pairs", log_q.size(), 3);
    chk_rec("t1_p0", 0, 1, 2, 2, 0);
    chk_rec("t1_p1", 1, 2, 1, 1, 0);
    chk_rec("t1_p2", 2, 5, 3, 3, 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_uniq", uniq_total, 3);
    chk("t1_err", sort_err, 0);

    // Frame 3,3,7: last word opens a new value
    log_q.delete();
    send_word(3, 0); send_word(3, 0); send_word(7, 1);
    drain();
    chk("t2_pairs", log_q.size(), 2);
    chk_rec("t2_p0", 0, 3, 2, 2, 0);
    chk_rec("t2_p1", 1, 7, 1, 1, 1);
    if (log_q.size() == 2) chk("t2_consecutive", log_q[1].cyc - log_q[0].cyc, 1);
    chk("t2_uniq", uniq_total, 2);

    // Single-word frame
    log_q.delete();
    done_cnt = 0;
    send_word(9, 1);
    drain();
    chk("t3_pairs", log_q.size(), 1);
    chk_rec("t3_p0", 0, 9, 1, 1, 1);
    if (log_q.size() == 1) chk("t3_latency", log_q[0].cyc - acc_cyc, 1);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_uniq", uniq_total, 1);

    // Frame 4,2,2 under back-pressure; flag survives until next frame's first accept
    log_q.delete();
    rdy_pct = 50;
    send_word(4, 0); send_word(2, 0); send_word(2, 1);
    drain();
    chk("t4_pairs", log_q.size(), 2);
    chk_rec("t4_p0", 0, 4, 1, 1, 0);
    chk_rec("t4_p1", 1, 2, 2, 2, 1);
    chk("t4_err_held", sort_err, 1);
    send_word(10, 1);
    @(negedge clk);
    #3;
    chk("t4_err_cleared", sort_err, 0);
    drain();
    rdy_pct = 100;

    // 20 copies of 6: CW=4 saturates at 15
    log_q.delete();
    for (int i = 0; i < 20; i++) send_word(6, i == 19);
    drain();
    chk("t5_pairs", log_q.size(), 1);
    chk_rec("t5_p0", 0, 6, 20, 15, 1);
    chk("t5_uniq4", uniq_total4, 1);

    // Reset mid-frame
    send_word(1, 0); send_word(1, 0);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    #2;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_count", out_count, 0);
    chk("t6_uniq", uniq_total, 0);
    chk("t6_err", sort_err, 0);
    log_q.delete();
    send_word(8, 1);
    drain();
    chk("t6_pairs", log_q.size(), 1);
    chk_rec("t6_p0", 0, 8, 1, 1, 1);

    // Random frames: mostly non-decreasing, occasional drops, long runs, random stalls
    for (int f = 0; f < 40; f++) begin
      rdy_pct = $urandom_range(30, 100);
      len     = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 24) : $urandom_range(1, 12);
      v       = $urandom_range(0, 15);
      for (int i = 0; i < len; i++) begin
        send_word(v, i == len - 1);
        case ($urandom_range(0, 9))
          5, 6, 7, 8: v = v + $urandom_range(1, 3);
          9:          if (v > 0) v = v - $urandom_range(1, v);
          default:    v = v;
        endcase
        if ($urandom_range(0, 5) == 0) begin
          @(negedge clk);
          #1 in_valid = 1'b0;
        end
      end
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
